// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int              XLEN      = 32;
   localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   // One buffered fetch result: the PC it was fetched from and the word returned.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fq_ring.sv
// DEPTH-entry ring buffer of fetch entries with push/pop/clear, an occupancy
// count and a registered head so the consumer sees a flop-driven entry.
module fq_ring
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
)(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          push_i,
   input  fetch_entry_t  push_data_i,
   input  logic          pop_i,
   output logic [CW-1:0] count_o,
   output fetch_entry_t  head_o
);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   fetch_entry_t  r_head;

   logic [AW-1:0] w_rd_next;
   logic [CW-1:0] w_count_after_pop;

   assign w_rd_next         = r_rd_ptr + AW'(1);
   assign w_count_after_pop = r_count - CW'(pop_i);

   // Storage array: data only, never reset.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         r_mem[r_wr_ptr] <= push_data_i;
      end
   end

   // Pointer and occupancy update; clear empties the ring in one edge.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push_i) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (pop_i) begin
            r_rd_ptr <= w_rd_next;
         end
         r_count <= r_count + CW'(push_i) - CW'(pop_i);
      end
   end

   // Registered head: when the ring would be empty after the pop, the pushed
   // word becomes the head directly; otherwise a pop exposes the next slot.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_head <= '0;
      end else if (!clear_i) begin
         if (push_i && (w_count_after_pop == '0)) begin
            r_head <= push_data_i;
         end else if (pop_i) begin
            r_head <= r_mem[w_rd_next];
         end
      end
   end

   // A push into a full ring means the issue side failed to reserve a slot.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(push_i && (r_count == CW'(DEPTH))));
      end
   end

   assign count_o = r_count;
   assign head_o  = r_head;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, 1-cycle memory
// request tracking with redirect kill, and a prefetch queue feeding decode.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            id_valid_o,
   input  logic            id_ready_i,
   output logic [XLEN-1:0] id_pc_o,
   output logic [XLEN-1:0] id_instr_o
);

   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] L_DEPTH = (CW + 1)'(DEPTH);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_req_pc;
   logic            r_inflight;
   logic            r_kill;

   logic [CW-1:0]   w_count;
   logic [CW:0]     w_occupied;
   logic            w_issue;
   logic            w_push;
   logic            w_pop;
   fetch_entry_t    w_push_data;
   fetch_entry_t    w_head;

   // An outstanding request already owns a queue slot, so issue only while
   // stored entries plus the in-flight one leave room.
   assign w_occupied  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
   assign w_issue     = start_i & ~redirect_i & (w_occupied < L_DEPTH);
   assign w_push      = imem_rvalid_i & r_inflight & ~r_kill & ~redirect_i;
   assign id_valid_o  = (w_count != '0) & ~redirect_i;
   assign w_pop       = id_valid_o & id_ready_i;

   assign w_push_data.pc    = r_req_pc;
   assign w_push_data.instr = imem_rdata_i;

   assign imem_req_o  = w_issue;
   assign imem_addr_o = r_fetch_pc;
   assign id_pc_o     = w_head.pc;
   assign id_instr_o  = w_head.instr;

   // PC sequencing and in-flight/kill tracking; redirect overrides issue.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
         r_kill     <= 1'b0;
      end else if (redirect_i) begin
         r_fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
         r_inflight <= 1'b0;
         r_kill     <= r_inflight;
      end else if (w_issue) begin
         r_fetch_pc <= r_fetch_pc + PC_STEP;
         r_req_pc   <= r_fetch_pc;
         r_inflight <= 1'b1;
         r_kill     <= 1'b0;
      end else begin
         r_inflight <= 1'b0;
      end
   end

   fq_ring #(
      .DEPTH (DEPTH)
   ) u_ring (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (redirect_i),
      .push_i      (w_push),
      .push_data_i (w_push_data),
      .pop_i       (w_pop),
      .count_o     (w_count),
      .head_o      (w_head)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based behavioural model of the fetch front end.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main DUT signals
   logic        rst = 1'b1, start = 1'b0, redir = 1'b0, ready = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0, redir_pc = '0;
   logic        req, vld;
   logic [31:0] addr, pc, instr;

   // wrap-around DUT signals
   logic        rst2 = 1'b1, start2 = 1'b0, rv2 = 1'b0;
   logic [31:0] rd2 = '0;
   logic        req2, vld2;
   logic [31:0] addr2, pc2, instr2;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .imem_req_o(req), .imem_addr_o(addr),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .redirect_i(redir), .redirect_pc_i(redir_pc),
      .id_valid_o(vld), .id_ready_i(ready),
      .id_pc_o(pc), .id_instr_o(instr)
   );

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk_i(clk), .rst_i(rst2), .start_i(start2),
      .imem_req_o(req2), .imem_addr_o(addr2),
      .imem_rvalid_i(rv2), .imem_rdata_i(rd2),
      .redirect_i(1'b0), .redirect_pc_i(32'h0),
      .id_valid_o(vld2), .id_ready_i(1'b1),
      .id_pc_o(pc2), .id_instr_o(instr2)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // behavioural model state
   fetch_entry_t mq[$];
   logic [31:0]  m_pc = 32'h0;
   logic [31:0]  m_req_pc = 32'h0;
   bit           m_infl = 1'b0;
   bit           m_kill = 1'b0;

   // memory model and observation
   bit           mem_pend = 1'b0;
   logic [31:0]  mem_addr = '0;
   bit           chk_on = 1'b0;
   logic         s_req, s_vld;
   logic [31:0]  s_addr, s_pc, s_instr;
   logic [31:0]  last_iss = '0;
   logic [31:0]  delivered[$];

   function automatic logic [31:0] dget(input int i);
      return (delivered.size() > i) ? delivered[i] : 32'hDEAD_BEEF;
   endfunction

   // one clock cycle: drive, check against model, advance model at the edge
   task automatic cycle(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                        input bit rdy, input bit spur);
      bit           e_req, e_vld, rv, pend_n;
      logic [31:0]  addr_n, dat;
      fetch_entry_t e;
      rv  = mem_pend | spur;
      dat = mem_pend ? (mem_addr ^ 32'hA5A5_0000) : 32'($urandom);
      rst = r; start = st; redir = rd; redir_pc = rpc; ready = rdy;
      rvalid = rv; rdata = dat;
      #3;
      e_req = st && !rd && ((mq.size() + int'(m_infl)) < DEPTH);
      e_vld = (mq.size() != 0) && !rd;
      s_req = req; s_addr = addr; s_vld = vld; s_pc = pc; s_instr = instr;
      if (chk_on) begin
         chk("imem_req", s_req, e_req);
         if (e_req) chk("imem_addr", s_addr, m_pc);
         chk("id_valid", s_vld, e_vld);
         if (e_vld) begin
            chk("id_pc", s_pc, mq[0].pc);
            chk("id_instr", s_instr, mq[0].instr);
         end
      end
      if (s_req === 1'b1) last_iss = s_addr;
      if (!r && (s_vld === 1'b1) && rdy) delivered.push_back(s_pc);
      pend_n = (s_req === 1'b1);
      addr_n = s_addr;
      @(posedge clk);
      if (r) begin
         mq.delete(); m_pc = 32'h0; m_infl = 1'b0; m_kill = 1'b0;
      end else if (rd) begin
         mq.delete();
         m_pc   = {rpc[31:2], 2'b00};
         m_kill = m_infl;
         m_infl = 1'b0;
      end else begin
         if (e_vld && rdy) void'(mq.pop_front());
         if (rv && m_infl && !m_kill) begin
            e.pc = m_req_pc; e.instr = dat;
            mq.push_back(e);
         end
         if (e_req) begin
            m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_infl = 1'b1; m_kill = 1'b0;
         end else begin
            m_infl = 1'b0;
         end
      end
      mem_pend = pend_n;
      mem_addr = addr_n;
      #1;
   endtask

   task automatic run(input int n, input bit st, input bit rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, st, 1'b0, 32'h0, rdy, 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] exp_wrap[4];
      logic [31:0] got_wrap[$];
      bit          pend2;
      logic [31:0] a2;
      bit          r, rd, st, rdy, sp;
      logic [31:0] tmp;

      // reset state
      @(posedge clk); #1;
      do_reset();
      chk_on = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("rst_req", s_req, 32'h0);
      chk("rst_valid", s_vld, 32'h0);
      chk("rst_pc", s_pc, 32'h0);
      chk("rst_instr", s_instr, 32'h0);

      // 1: free run, one instruction per cycle in PC order
      do_reset();
      delivered.delete();
      run(14, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) chk("t1_seq", dget(i), 32'(4 * i));

      // 2: decode stalled, queue fills to DEPTH then fetch stops
      do_reset();
      run(10, 1'b1, 1'b0);
      chk("t2_req_low", s_req, 32'h0);
      chk("t2_head_pc", s_pc, 32'h0);
      chk("t2_head_instr", s_instr, 32'hA5A5_0000);
      delivered.delete();
      run(8, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) chk("t2_release", dget(i), 32'(4 * i));

      // 3: redirect with three queued and one in flight
      do_reset();
      run(4, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b0);
      delivered.delete();
      run(8, 1'b1, 1'b1);
      chk("t3_first", dget(0), 32'h0000_0100);
      chk("t3_second", dget(1), 32'h0000_0104);

      // 4: back-to-back redirects, last one wins
      delivered.delete();
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
      run(6, 1'b1, 1'b1);
      chk("t4_first", dget(0), 32'h0000_0300);
      chk("t4_second", dget(1), 32'h0000_0304);

      // 6: start dropped with a request in flight
      do_reset();
      run(5, 1'b1, 1'b1);
      tmp = last_iss;
      delivered.delete();
      run(6, 1'b0, 1'b1);
      chk("t6_last_delivered", (delivered.size() > 0) ? delivered[$] : 32'hDEAD_BEEF, tmp);
      chk("t6_drained", s_vld, 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("t6_resume_req", s_req, 32'h1);
      chk("t6_resume_addr", s_addr, tmp + 32'd4);

      // randomized traffic: stalls, start toggles, redirects, resets, stray responses
      for (int i = 0; i < 1500; i++) begin
         r   = ($urandom_range(199) == 0);
         rd  = ($urandom_range(19) == 0);
         st  = ($urandom_range(99) < 85);
         rdy = ($urandom_range(99) < 60);
         sp  = ($urandom_range(9) == 0);
         cycle(r, st, rd, 32'($urandom), rdy, sp);
      end

      // 5: PC wrap from a reset PC near the top of the address space
      exp_wrap[0] = 32'hFFFF_FFF8; exp_wrap[1] = 32'hFFFF_FFFC;
      exp_wrap[2] = 32'h0000_0000; exp_wrap[3] = 32'h0000_0004;
      rst2 = 1'b1; start2 = 1'b0; rv2 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst2 = 1'b0; start2 = 1'b1; pend2 = 1'b0; a2 = '0;
      for (int k = 0; k < 10; k++) begin
         rv2 = pend2;
         rd2 = a2 ^ 32'hA5A5_0000;
         #3;
         if (vld2 === 1'b1) got_wrap.push_back(pc2);
         pend2 = (req2 === 1'b1);
         a2    = addr2;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++)
         chk("t5_wrap", (got_wrap.size() > i) ? got_wrap[i] : 32'hDEAD_BEEF, exp_wrap[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
